// File: rtl/oled_framebuffer.sv
// oled_framebuffer: 128x64 monochrome frame buffer for an SSD1306-style panel.
// Pixels are written by read-modify-write into a 1024x8 single-port RAM laid out
// in GDDRAM horizontal-addressing order, and the whole buffer is streamed as
// 1024 bytes (page 0 first) over a valid/ready byte interface.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   px_we/px_x/px_y/px_val, px_ready - single-pixel write request / acceptance
//   clr_req             - zero the whole buffer
//   frame_start         - stream one full frame
//   busy                - any operation in progress
//   out_valid/out_ready/out_data/out_last - byte stream to the display stage
module oled_framebuffer #(
    parameter bit AUTO_CLEAR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       px_we,
    input  logic [6:0] px_x,
    input  logic [5:0] px_y,
    input  logic       px_val,
    output logic       px_ready,
    input  logic       clr_req,
    input  logic       frame_start,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1024;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PX_RD,
        PX_WR,
        CLEAR,
        STR_RD,
        STR_OUT
    } state_t;

    localparam state_t RST_STATE = AUTO_CLEAR ? CLEAR : IDLE;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic [ADDR_W-1:0]   clr_addr, clr_addr_n;
    logic [ADDR_W-1:0]   pix_addr;
    logic [2:0]          pix_bit;
    logic                pix_val;
    logic                pix_load;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data;
    logic                ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;

    assign px_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign out_data = rd_data;

    // Next-state, counter and RAM-port control; exactly one RAM access per state.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        clr_addr_n = clr_addr;
        pix_load   = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = pix_addr;
        ram_wdata  = rd_data;
        case (state)
            IDLE: begin
                // Fixed priority; losing requests are simply not sampled.
                if (clr_req) begin
                    state_n = CLEAR;
                end else if (frame_start) begin
                    idx_n   = '0;
                    state_n = STR_RD;
                end else if (px_we) begin
                    pix_load = 1'b1;
                    state_n  = PX_RD;
                end
            end
            PX_RD: begin
                ram_re  = 1'b1;
                state_n = PX_WR;
            end
            PX_WR: begin
                // Only the target bit of the byte just read is replaced.
                ram_we             = 1'b1;
                ram_wdata[pix_bit] = pix_val;
                state_n            = IDLE;
            end
            CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr;
                ram_wdata  = '0;
                clr_addr_n = clr_addr + ADDR_W'(1);
                if (clr_addr == LAST_IDX) begin
                    state_n = IDLE;
                end
            end
            STR_RD: begin
                ram_re   = 1'b1;
                ram_addr = idx;
                state_n  = STR_OUT;
            end
            STR_OUT: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + ADDR_W'(1);
                        state_n = STR_RD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters, pixel latch, read-data and stream flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            idx       <= '0;
            clr_addr  <= '0;
            pix_addr  <= '0;
            pix_bit   <= '0;
            pix_val   <= 1'b0;
            rd_data   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            clr_addr <= clr_addr_n;
            if (pix_load) begin
                pix_addr <= {px_y[5:3], px_x};
                pix_bit  <= px_y[2:0];
                pix_val  <= px_val;
            end
            if (ram_re) begin
                rd_data <= mem[ram_addr];
            end
            out_valid <= (state_n == STR_OUT);
            out_last  <= (state_n == STR_OUT) && (idx_n == LAST_IDX);
        end
    end

    // RAM array; not reset, and a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

endmodule
